sound_event_counter: RTL

//   Multi-channel successor to the single-channel sound pulse counter.

---
 rtl/sound_pkg.sv | 24 ++
 rtl/sound_tick_div.sv | 38 +++
 rtl/sound_event_counter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound event counter slice.
// Holds the game-state encoding that enables counting, the state width,
// and a ceiling-log2 helper used to size the tick divider and holdoff counters.
package sound_pkg;

   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ARM_STATE = 3'b110;

   // Ceiling log2, usable in constant expressions for register sizing.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Register width able to hold 0..value-1, never narrower than one bit.
   function automatic int widthFor(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/sound_tick_div.sv
// Sample tick generator for the sound event counter.
// A counter runs 0..DIV-1 on CLK and flags tick for the single cycle spent at
// DIV-1, then wraps. This is a clock enable, not a derived clock.
// Ports:
//   CLK  - system clock
//   ena  - asynchronous active-low reset
//   tick - one-cycle sample enable every DIV cycles
import sound_pkg::*;

module sound_tick_div #(
   parameter int DIV = 50000
) (
   input  logic CLK,
   input  logic ena,
   output logic tick
);

   localparam int DW = widthFor(DIV);
   localparam logic [DW-1:0] LAST = DW'(DIV - 1);

   logic [DW-1:0] count_q;
   logic [DW-1:0] count_d;

   // With DIV=1, LAST is 0, so the counter parks at 0 and tick stays high.
   always_comb begin
      tick    = (count_q == LAST);
      count_d = tick ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge ena) begin
      if (!ena) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sound_event_counter.sv
// Multi-channel sound event counter.
// Each AOUT line is double-flopped into the CLK domain and sampled on the
// divided tick. A channel accepts one event per low->high sequence and bumps a
// saturating counter while the game is in ARM_STATE; outside it an event either
// forces the count to CNT_MAX (FORCE_MAX=1) or is ignored (FORCE_MAX=0).
// Optional build macro: SOUND_CNT_HOLDOFF_EN adds a per-channel refractory
// period of HOLDOFF ticks after each event before the channel may re-arm.
// Ports:
//   CLK   - system clock
//   ena   - asynchronous active-low reset
//   state - game FSM state
//   clr   - synchronous clear of all channels
//   AOUT  - raw detector outputs (asynchronous)
//   cnt   - packed channel counts, channel i at cnt[i*CNT_W +: CNT_W]
//   full  - per-channel count == CNT_MAX
//   evt   - one-cycle pulse per accepted event
import sound_pkg::*;

module sound_event_counter #(
   parameter int N         = 2,
   parameter int CNT_W     = 2,
   parameter int CNT_MAX   = 3,
   parameter int DIV       = 50000,
   parameter int FORCE_MAX = 1,
   parameter int HOLDOFF   = 4
) (
   input  logic               CLK,
   input  logic               ena,
   input  logic [STATE_W-1:0] state,
   input  logic               clr,
   input  logic [N-1:0]       AOUT,
   output logic [N*CNT_W-1:0] cnt,
   output logic [N-1:0]       full,
   output logic [N-1:0]       evt
);

   localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);

   logic tick;

   sound_tick_div #(
      .DIV (DIV)
   ) u_tick_div (
      .CLK  (CLK),
      .ena  (ena),
      .tick (tick)
   );

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic             sync1_q;
      logic             sync2_q;
      logic             armed_q;
      logic             armed_d;
      logic             evt_q;
      logic             evt_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             fire;
      logic             holdDone;

`ifdef SOUND_CNT_HOLDOFF_EN
      localparam int HW = widthFor(HOLDOFF + 1);
      logic [HW-1:0] hold_q;
      logic [HW-1:0] hold_d;

      // Refractory counter: reloaded on every event, runs down on ticks,
      // and blocks re-arming until it reaches zero so echoes are rejected.
      always_comb begin
         hold_d = hold_q;
         if (tick && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
         end
         if (fire) begin
            hold_d = HW'(HOLDOFF);
         end
         if (clr) begin
            hold_d = '0;
         end
      end

      always_ff @(posedge CLK or negedge ena) begin
         if (!ena) begin
            hold_q <= '0;
         end else begin
            hold_q <= hold_d;
         end
      end

      assign holdDone = (hold_q == '0);
`else
      assign holdDone = 1'b1;
`endif

      // Arm/fire rule: a high sample on a tick fires only when armed, and a
      // low sample re-arms, so a long high produces a single event. clr has
      // the final say over count, arming and the event pulse.
      always_comb begin
         fire    = tick && sync2_q && armed_q;
         armed_d = armed_q;
         cnt_d   = cnt_q;
         evt_d   = 1'b0;
         if (tick) begin
            if (!sync2_q && holdDone) begin
               armed_d = 1'b1;
            end else if (fire) begin
               armed_d = 1'b0;
            end
         end
         if (fire) begin
            evt_d = 1'b1;
            if (state == ARM_STATE) begin
               if (cnt_q < CNT_MAX_V) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (FORCE_MAX != 0) begin
               cnt_d = CNT_MAX_V;
            end
         end
         if (clr) begin
            cnt_d   = '0;
            armed_d = 1'b1;
            evt_d   = 1'b0;
         end
      end

      always_ff @(posedge CLK or negedge ena) begin
         if (!ena) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            armed_q <= 1'b1;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= AOUT[i];
            sync2_q <= sync1_q;
            armed_q <= armed_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
         end
      end

      assign cnt[i*CNT_W +: CNT_W] = cnt_q;
      assign full[i]               = (cnt_q == CNT_MAX_V);
      assign evt[i]                = evt_q;
   end

endmodule
